ir_move_scheduler: RTL and testbench
====================================

// Module: ir_move_scheduler
// PURPOSE
//  Sequences the pong paddle-control IR sensors (P1 up/down, P2 up/down) onto one shared paddle-update port.
//  Per channel: synchronise, debounce and hold the raw sensor, then turn a held detection into periodic move events.
//  A round-robin arbiter grants pending events one at a time over a valid/ready handshake to the paddle position logic.
//  Sits between the top-level sensor pins and the paddle/game-state block.
// PARAMETERS
//  N_CH          4          sensor channels; pair (2k,2k+1) = player k (up,down); must be even
//  CH_W          2          width of channel index (clog2 N_CH)
//  CNT_W         20         width of all per-channel counters
//  DEBOUNCE_CYC  1000       consecutive synced-high cycles before det rises (10 us @100 MHz)
//  HOLD_CYC      20000      consecutive synced-low cycles before det falls (200 us)
//  REPEAT_CYC    1000000    cycles between repeat events while det held (10 ms)
// PORTS
//  clk_100MHz  in   1      system clock, all logic on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  enable      in   1      game running; low suppresses and flushes move events
//  ir_raw      in   N_CH   raw asynchronous IR sensor levels, 1 = detection
//  det         out  N_CH   filtered detection level per channel
//  upd_valid   out  1      move request offered
//  upd_ch      out  CH_W   channel (player/direction) of offered move
//  upd_ready   in   1      paddle logic accepts move this cycle
//  overrun     out  1      1-cycle pulse: event hit an already-pending channel (merged)
// BEHAVIOUR
//  Reset (async assert, sync release): sync FFs, det, counters, pend, upd_valid, upd_ch, overrun = 0; last_grant = N_CH-1.
//  Sync: 2-FF synchroniser per ir_raw bit; everything below uses the synced bit s[i].
//  Debounce: det[i]=0 -> rises after s[i]=1 for DEBOUNCE_CYC consecutive cycles; det[i]=1 -> falls after s[i]=0
//   for HOLD_CYC consecutive cycles; any opposite sample restarts the count. Counters saturate, never wrap.
//  Events: ev[i] pulses in the cycle det[i] rises; while det[i]=1, repeat counter pulses ev[i] every REPEAT_CYC
//   cycles after that; counter clears when det[i] falls. ev[i] forced 0 while enable=0.
//  Pending: ev[i] sets pend[i] next cycle. ev[i] with pend[i]=1 and channel not being accepted -> overrun=1 next cycle.
//   Same-cycle accept of ch i and ev[i] -> pend[i] stays 1, no overrun.
//  Conflict: both bits of a pair pending and neither is the channel currently offered -> both cleared, no move issued.
//   Conflict takes effect the cycle after both bits are set, before arbitration sees them.
//  enable=0: pend cleared every cycle; an in-flight offer is NOT withdrawn, it completes normally.
//  Arbiter FSM (2 states):
//   IDLE : if any pend (post-conflict), choose first set index searching last_grant+1 upward, wrapping at N_CH;
//          register upd_ch, upd_valid=1 -> OFFER. Else stay, upd_valid=0.
//   OFFER: upd_valid=1, upd_ch stable until upd_valid&&upd_ready; then clear pend[upd_ch], last_grant=upd_ch,
//          upd_valid=0 -> IDLE.
//  Latency: det rise at cycle t -> pend at t+1 -> upd_valid at t+2 (from IDLE). Max 1 move per 2 cycles.
//  det observes raw input after 2 sync cycles + DEBOUNCE_CYC.
// STRUCTURE
//  Shared header pong_defs.vh: channel index constants (CH_P1_UP=0, CH_P1_DN=1, CH_P2_UP=2, CH_P2_DN=3),
//   arbiter state encodings, default timing constants.
//  Sub-module ir_channel_filter (one per channel, generate loop): sync + debounce/hold + repeat -> det, ev.
//  Top: pend vector, conflict cancel, overrun, round-robin arbiter FSM.
// TESTING (use DEBOUNCE_CYC=4, HOLD_CYC=8, REPEAT_CYC=20)
//  ir_raw[0] high 3 cycles then low -> det[0] never rises, no upd_valid.
//  ir_raw[0] held high, upd_ready=1 -> det[0] rises 6 cycles later; upd_valid with upd_ch=0 two cycles later,
//   then repeated every 20 cycles; ir_raw low 7 cycles then high -> det stays 1.
//  ir_raw[1] and ir_raw[3] rise same cycle, upd_ready=1 -> upd_ch=1 accepted, then upd_ch=3; second
//   round of same pair -> order 3 then 1 not required; rotation from last_grant verified.
//  ir_raw[2] and ir_raw[3] rise same cycle -> both pend cleared, no upd_valid, overrun=0.
//  upd_ready held 0 for 50 cycles with ch0 held -> upd_ch=0 stable, overrun pulses on each repeat event.
//  enable dropped during OFFER -> offer completes on upd_ready, pend flushed, no further upd_valid;
//   reset_n low mid-OFFER -> upd_valid=0 immediately, det=0.

Source files
------------

// File: rtl/ir_move_scheduler_pkg.sv
// Shared types and constants for the IR paddle move scheduler.
// Channel pair (2k, 2k+1) belongs to player k as (up, down).
package ir_move_scheduler_pkg;

  localparam int CH_UP = 0;
  localparam int CH_DN = 1;

  localparam int DEF_CNT_W        = 20;
  localparam int DEF_DEBOUNCE_CYC = 1000;
  localparam int DEF_HOLD_CYC     = 20000;
  localparam int DEF_REPEAT_CYC   = 1000000;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ir_move_scheduler_if.sv
// Move-update handshake between the scheduler and the paddle logic.
// The master offers a channel index; the slave accepts with ready.
interface ir_move_scheduler_if #(
  parameter int CH_W = 2
) ();

  logic            upd_valid;
  logic [CH_W-1:0] upd_ch;
  logic            upd_ready;

  modport master (
    output upd_valid,
    output upd_ch,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_ch,
    output upd_ready
  );

endinterface

// File: rtl/ir_move_scheduler_filter.sv
// One IR channel: 2-FF sync, debounce/hold filter, repeat-event timer.
// ev pulses in the first det=1 cycle and every REPEAT_CYC cycles after.
module ir_channel_filter
  import ir_move_scheduler_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic det,
  output logic ev
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic             det_q;
  logic             ev_q;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             falling;

  assign s       = sync_q[1];
  assign falling = det_q && !s && (deb_cnt >= HLD_LAST);
  assign det     = det_q;
  assign ev      = ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      det_q   <= 1'b0;
      ev_q    <= 1'b0;
      deb_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      ev_q   <= 1'b0;
      if (!det_q) begin
        rep_cnt <= '0;
        if (!s) begin
          deb_cnt <= '0;
        end else if (deb_cnt >= DEB_LAST) begin
          det_q   <= 1'b1;
          deb_cnt <= '0;
          ev_q    <= 1'b1;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        if (s) begin
          deb_cnt <= '0;
        end else if (falling) begin
          det_q   <= 1'b0;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
        // repeat timer only runs while the detection is held
        if (falling) begin
          rep_cnt <= '0;
        end else if (rep_cnt >= REP_LAST) begin
          rep_cnt <= '0;
          ev_q    <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ir_move_scheduler.sv
// Turns filtered IR detections into paddle move requests, one at a
// time, via pending bits, pair-conflict cancel and a round-robin FSM.
module ir_move_scheduler
  import ir_move_scheduler_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   ir_raw,
  output logic [N_CH-1:0]   det,
  ir_move_scheduler_if.master upd,
  output logic              overrun
);

  logic [N_CH-1:0] ev_raw;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] pend_eff;
  logic [N_CH-1:0] pend_nxt;
  logic [N_CH-1:0] acc_vec;
  logic            accept;
  logic            ov_nxt;

  arb_state_t      state_q;
  arb_state_t      state_nxt;
  logic            valid_q;
  logic            valid_nxt;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ch_nxt;
  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] last_nxt;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] cand;
  logic            found;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ir_channel_filter #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_filt (
      .clk   (clk_100MHz),
      .rst_n (reset_n),
      .raw   (ir_raw[i]),
      .det   (det[i]),
      .ev    (ev_raw[i])
    );
  end

  assign ev     = ev_raw & {N_CH{enable}};
  assign accept = valid_q & upd.upd_ready;

  // up+down together cancel out unless one of them is already offered
  for (genvar g = 0; g < N_CH / 2; g++) begin : g_pair
    localparam logic [CH_W-1:0] UP = CH_W'(2 * g + CH_UP);
    localparam logic [CH_W-1:0] DN = CH_W'(2 * g + CH_DN);
    logic offered;
    logic cancel;
    assign offered = valid_q && (ch_q == UP || ch_q == DN);
    assign cancel  = pend_q[2*g+CH_UP] & pend_q[2*g+CH_DN] & ~offered;
    assign pend_eff[2*g+CH_UP] = pend_q[2*g+CH_UP] & ~cancel;
    assign pend_eff[2*g+CH_DN] = pend_q[2*g+CH_DN] & ~cancel;
  end

  always_comb begin
    acc_vec = '0;
    if (accept) acc_vec[ch_q] = 1'b1;
  end

  assign pend_nxt = enable ? ((pend_eff & ~acc_vec) | ev) : '0;
  assign ov_nxt   = |(ev & pend_eff & ~acc_vec);

  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_q) + k) % N_CH);
      if (!found && pend_eff[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    valid_nxt = valid_q;
    ch_nxt    = ch_q;
    last_nxt  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        valid_nxt = 1'b0;
        if (enable && found) begin
          ch_nxt    = pick;
          valid_nxt = 1'b1;
          state_nxt = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        valid_nxt = 1'b1;
        if (upd.upd_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = ch_q;
          state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      last_q  <= CH_W'(N_CH - 1);
      pend_q  <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_nxt;
      valid_q <= valid_nxt;
      ch_q    <= ch_nxt;
      last_q  <= last_nxt;
      pend_q  <= pend_nxt;
      overrun <= ov_nxt;
    end
  end

  assign upd.upd_valid = valid_q;
  assign upd.upd_ch    = ch_q;

endmodule

// File: tb/tb_ir_move_scheduler.sv
// Directed bench for ir_move_scheduler with short timing parameters.
// Accepted moves are checked in order against a queue of expected channels.
module tb_ir_move_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] ir_raw = '0;
  logic [3:0] det;
  logic       overrun;

  int          checks = 0;
  int          errors = 0;
  int unsigned sb[$];

  ir_move_scheduler_if #(.CH_W(2)) upd_if ();

  ir_move_scheduler #(
    .N_CH         (4),
    .CH_W         (2),
    .CNT_W        (20),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (8),
    .REPEAT_CYC   (20)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .ir_raw     (ir_raw),
    .det        (det),
    .upd        (upd_if.master),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (upd_if.upd_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk("valid_timeout", 32'(upd_if.upd_valid), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && upd_if.upd_valid && upd_if.upd_ready) begin
      int unsigned exp_ch;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_move observed=%0d expected=none",
               upd_if.upd_ch);
      end
      if (sb.size() != 0) begin
        exp_ch = sb.pop_front();
        checks++;
        assert (32'(upd_if.upd_ch) === exp_ch) else begin
          errors++;
          $error("FAIL move_order observed=%0d expected=%0d",
                 upd_if.upd_ch, exp_ch);
        end
      end
    end
  end

  initial begin
    logic saw_v;
    logic saw_o;
    logic saw_d;
    logic stable;
    int   ovc;

    upd_if.upd_ready = 1'b0;
    enable  = 1'b1;
    reset_n = 1'b0;
    tick(3);
    chk("rst_det", 32'(det), 0);
    chk("rst_valid", 32'(upd_if.upd_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    tick(2);

    // short glitch never reaches the debounce threshold
    ir_raw = 4'b0001;
    tick(3);
    ir_raw = 4'b0000;
    saw_v = 1'b0;
    saw_d = 1'b0;
    repeat (20) begin
      tick(1);
      saw_v |= upd_if.upd_valid;
      saw_d |= det[0];
    end
    chk("glitch_det", 32'(saw_d), 0);
    chk("glitch_valid", 32'(saw_v), 0);

    // held detection: latency, first move, repeat
    upd_if.upd_ready = 1'b1;
    ir_raw = 4'b0001;
    sb.push_back(0);
    tick(5);
    chk("det_before", 32'(det[0]), 0);
    tick(1);
    chk("det_rise", 32'(det[0]), 1);
    tick(1);
    chk("valid_before", 32'(upd_if.upd_valid), 0);
    tick(1);
    chk("valid_first", 32'(upd_if.upd_valid), 1);
    chk("ch_first", 32'(upd_if.upd_ch), 0);
    sb.push_back(0);
    tick(19);
    chk("repeat_before", 32'(upd_if.upd_valid), 0);
    tick(1);
    chk("repeat_valid", 32'(upd_if.upd_valid), 1);
    ir_raw = 4'b0000;
    tick(7);
    ir_raw = 4'b0001;
    saw_d = 1'b0;
    repeat (10) begin
      tick(1);
      saw_d |= ~det[0];
    end
    chk("hold_short_low", 32'(saw_d), 0);
    sb.push_back(0);
    wait_valid(10);
    chk("repeat2_ch", 32'(upd_if.upd_ch), 0);
    tick(1);
    ir_raw = 4'b0000;
    tick(14);
    chk("det_fall", 32'(det[0]), 0);
    wait_drain(5);

    // two down sensors: round-robin from last_grant=0, twice
    ir_raw = 4'b1010;
    sb.push_back(1);
    sb.push_back(3);
    sb.push_back(1);
    sb.push_back(3);
    wait_drain(60);
    chk("rr_det", 32'(det), 32'b1010);
    ir_raw = 4'b0000;
    tick(15);
    chk("rr_det_fall", 32'(det), 0);

    // P2 up and down together cancel
    ir_raw = 4'b1100;
    saw_v = 1'b0;
    saw_o = 1'b0;
    repeat (30) begin
      tick(1);
      saw_v |= upd_if.upd_valid;
      saw_o |= overrun;
    end
    chk("conflict_valid", 32'(saw_v), 0);
    chk("conflict_overrun", 32'(saw_o), 0);
    chk("conflict_det", 32'(det), 32'b1100);
    ir_raw = 4'b0000;
    tick(15);
    chk("conflict_det_fall", 32'(det), 0);

    // stalled consumer: stable offer, overrun on each repeat
    upd_if.upd_ready = 1'b0;
    ir_raw = 4'b0001;
    sb.push_back(0);
    wait_valid(12);
    chk("stall_ch", 32'(upd_if.upd_ch), 0);
    stable = 1'b1;
    ovc = 0;
    repeat (50) begin
      tick(1);
      stable &= upd_if.upd_valid && (upd_if.upd_ch == 2'd0);
      ovc += int'(overrun);
    end
    chk("stall_stable", 32'(stable), 1);
    chk("stall_overruns", 32'(ovc), 2);

    // enable drop mid-offer: offer completes, then nothing
    enable = 1'b0;
    tick(3);
    chk("dis_valid_held", 32'(upd_if.upd_valid), 1);
    chk("dis_ch_held", 32'(upd_if.upd_ch), 0);
    upd_if.upd_ready = 1'b1;
    tick(1);
    chk("dis_accepted", 32'(upd_if.upd_valid), 0);
    saw_v = 1'b0;
    repeat (30) begin
      tick(1);
      saw_v |= upd_if.upd_valid;
    end
    chk("dis_no_valid", 32'(saw_v), 0);
    chk("dis_drain", sb.size(), 0);

    // reset asserted mid-offer clears outputs at once
    upd_if.upd_ready = 1'b0;
    enable = 1'b1;
    wait_valid(30);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(upd_if.upd_valid), 0);
    chk("async_rst_det", 32'(det), 0);
    chk("async_rst_overrun", 32'(overrun), 0);
    tick(2);
    ir_raw = 4'b0000;
    reset_n = 1'b1;
    tick(3);
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
